// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response encodings and address-decode helper for the register bank.
package axi4_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Number of byte-offset address bits below the register index.
    function automatic int byte_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_wr_ctrl.sv
// AXI4-Lite write path: independent AW/W holds, commit one cycle after both are held, B response.
// AW/W are refused while a hold is full or a B response is pending; B is held until bready.
module axi4_lite_wr_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int                     DATA_W   = 32,
    parameter int                     ADDR_W   = 12,
    parameter int                     NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0]    RO_MASK  = '0,
    localparam int                    LSB      = byte_lsb(DATA_W),
    localparam int                    IDX_W    = ADDR_W - LSB,
    localparam int                    STRB_W   = DATA_W / 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [STRB_W-1:0]   wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    output logic                wr_en,
    output logic [IDX_W-1:0]    wr_idx,
    output logic [DATA_W-1:0]   wr_data,
    output logic [STRB_W-1:0]   wr_strb,
    output logic [NUM_REGS-1:0] wr_pulse
);

    logic                aw_held_q, aw_held_d;
    logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
    logic                w_held_q, w_held_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic                bvalid_q, bvalid_d;
    resp_t               bresp_q, bresp_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS-1:0] hit;
    logic                commit, wr_ok;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^awaddr[LSB-1:0];

    assign awready  = !aw_held_q && !bvalid_q;
    assign wready   = !w_held_q && !bvalid_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign wr_pulse = wr_pulse_q;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = (aw_idx_q == IDX_W'(i));
        end
    end

    // Out-of-range indices produce no hit, so they fail the same way as read-only ones.
    assign wr_ok   = |(hit & ~RO_MASK);
    assign commit  = aw_held_q && w_held_q;
    assign wr_en   = commit && wr_ok;
    assign wr_idx  = aw_idx_q;
    assign wr_data = w_data_q;
    assign wr_strb = w_strb_q;

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = wr_en ? hit : '0;
        if (awvalid && awready) begin
            aw_held_d = 1'b1;
            aw_idx_d  = awaddr[ADDR_W-1:LSB];
        end
        if (wvalid && wready) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

endmodule

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite register bank with byte-strobed RW registers and hw_in-sourced RO registers.
// Read data is registered one cycle after AR; AR is refused while R is pending until rready.
module axi4_lite_regbank
    import axi4_lite_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 12,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    output logic                         bvalid,
    input  logic                         bready,
    output logic [1:0]                   bresp,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [ADDR_W-1:0]            araddr,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int LSB    = byte_lsb(DATA_W);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int STRB_W = DATA_W / 8;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;

    axi4_lite_wr_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_wr_ctrl (
        .clk      (clk),
        .reset    (reset),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .bvalid   (bvalid),
        .bready   (bready),
        .bresp    (bresp),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .wr_pulse (wr_pulse)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_W-1:0] val_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                val_q <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(g))) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        val_q[b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end

        assign reg_out[g*DATA_W +: DATA_W] = val_q;
    end

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    resp_t             rresp_q, rresp_d;
    logic [IDX_W-1:0]  ar_idx;
    logic              unused_in;

    assign unused_in = ^{araddr[LSB-1:0], hw_in};

    assign ar_idx  = araddr[ADDR_W-1:LSB];
    assign arready = !rvalid_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // Sampling reg_out at the AR edge yields the pre-write value when a commit lands on the same edge.
    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rresp_d = RESP_OKAY;
                rdata_d = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : reg_out[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (arvalid && arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end else if (rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule
